// File: rtl/if_id_ctrl_pkg.sv
// rtl/if_id_ctrl_pkg.sv - shared types and constants for the IF/ID sequencing controller
package if_id_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MISS      = 2'd1,
        ST_MISS_KILL = 2'd2,
        ST_HALT      = 2'd3
    } state_t;

    // Instruction word loaded into IF/ID on a flush
    localparam logic [15:0] NOP_INSN = 16'h0000;

    localparam int MISS_TIMEOUT_DEF = 64;

endpackage

// File: rtl/if_id_ctrl_if.sv
// rtl/if_id_ctrl_if.sv - fetch/icache/ID handshake bundle; counters present only with IF_ID_CTRL_PERF_EN
interface if_id_ctrl_if #(
    parameter int CNT_W = 16
);
    logic hit_fetch;
    logic refill_done;
    logic branch_taken;
    logic load_use;
    logic halt;
    logic pc_we;
    logic pc_sel;
    logic ifid_we;
    logic ifid_flush;
    logic refill_req;
    logic timeout_err;
`ifdef IF_ID_CTRL_PERF_EN
    logic [CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output hit_fetch, refill_done, branch_taken, load_use, halt,
        input  pc_we, pc_sel, ifid_we, ifid_flush, refill_req, timeout_err,
        input  miss_cnt, stall_cnt
    );
    modport slave (
        input  hit_fetch, refill_done, branch_taken, load_use, halt,
        output pc_we, pc_sel, ifid_we, ifid_flush, refill_req, timeout_err,
        output miss_cnt, stall_cnt
    );
`else
    modport master (
        output hit_fetch, refill_done, branch_taken, load_use, halt,
        input  pc_we, pc_sel, ifid_we, ifid_flush, refill_req, timeout_err
    );
    modport slave (
        input  hit_fetch, refill_done, branch_taken, load_use, halt,
        output pc_we, pc_sel, ifid_we, ifid_flush, refill_req, timeout_err
    );
`endif
endinterface

// File: rtl/if_id_ctrl_miss_timer.sv
// rtl/if_id_ctrl_miss_timer.sv - saturating refill wait counter with clear, enable and timeout
module miss_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    logic [15:0] count_q;
    logic [15:0] count_d;

    // Count wait cycles already elapsed; clear wins over enable
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 16'd0;
        end else if (en && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Current wait cycle is the LIMIT-th (or later) one
    assign timeout = en && (count_q >= 16'(LIMIT - 1));

endmodule

// File: rtl/if_id_ctrl.sv
// rtl/if_id_ctrl.sv - IF/ID register and PC sequencing controller; optional counters via IF_ID_CTRL_PERF_EN
module if_id_ctrl
    import if_id_ctrl_pkg::*;
#(
    parameter int MISS_TIMEOUT = MISS_TIMEOUT_DEF,
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    if_id_ctrl_if.slave  bus
);
    state_t state_q, state_d;
    logic   err_q, err_d;
    logic   pc_we, pc_sel, ifid_we, ifid_flush, refill_req, timeout_err;
    logic   waiting, timer_clr, timeout, miss_enter;

    assign waiting = (state_q == ST_MISS) || (state_q == ST_MISS_KILL);

    miss_timer #(.LIMIT(MISS_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (waiting && rst_n),
        .timeout (timeout)
    );

    // Next state and per-cycle pipeline enables
    always_comb begin
        state_d    = state_q;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        refill_req = 1'b0;
        timer_clr  = 1'b0;
        miss_enter = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.branch_taken) begin
                    pc_we      = 1'b1;
                    pc_sel     = 1'b1;
                    ifid_flush = 1'b1;
                end else if (bus.halt) begin
                    state_d = ST_HALT;
                end else if (bus.load_use) begin
                    if (!bus.hit_fetch) begin
                        refill_req = 1'b1;
                        miss_enter = 1'b1;
                    end
                end else if (!bus.hit_fetch) begin
                    ifid_flush = 1'b1;
                    refill_req = 1'b1;
                    miss_enter = 1'b1;
                end else begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
                if (miss_enter) begin
                    state_d   = ST_MISS;
                    timer_clr = 1'b1;
                end
            end
            ST_MISS: begin
                refill_req = 1'b1;
                ifid_flush = !bus.load_use;
                if (bus.branch_taken) begin
                    pc_we      = 1'b1;
                    pc_sel     = 1'b1;
                    ifid_flush = 1'b1;
                    state_d    = bus.refill_done ? ST_RUN : ST_MISS_KILL;
                end else if (bus.refill_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_MISS_KILL: begin
                refill_req = 1'b1;
                ifid_flush = 1'b1;
                if (bus.branch_taken) begin
                    pc_we  = 1'b1;
                    pc_sel = 1'b1;
                end
                if (bus.refill_done) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        err_d       = err_q || (timeout && !bus.refill_done);
        timeout_err = err_d && (state_q != ST_HALT);
        if (!rst_n) begin
            state_d     = ST_RUN;
            pc_we       = 1'b0;
            pc_sel      = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b0;
            refill_req  = 1'b0;
            timeout_err = 1'b0;
            miss_enter  = 1'b0;
        end
    end

    // State and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.pc_sel      = pc_sel;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.refill_req  = refill_req;
    assign bus.timeout_err = timeout_err;

`ifdef IF_ID_CTRL_PERF_EN
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating miss and stall counters
    always_comb begin
        miss_cnt_d  = miss_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (miss_enter && miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
        if (rst_n && state_q != ST_HALT && !pc_we && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            miss_cnt_q  <= miss_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.miss_cnt  = rst_n ? miss_cnt_q  : '0;
    assign bus.stall_cnt = rst_n ? stall_cnt_q : '0;
`endif

endmodule

// File: tb/tb_if_id_ctrl.sv
// tb/tb_if_id_ctrl.sv - vector table plus randomized reference-model check of if_id_ctrl
module tb_if_id_ctrl;
    localparam int TO    = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    if_id_ctrl_if #(.CNT_W(CNT_W)) ifc ();

    if_id_ctrl #(.MISS_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // in : {rst_n, hit_fetch, refill_done, branch_taken, load_use, halt}
    // out: {pc_we, pc_sel, ifid_we, ifid_flush, refill_req, timeout_err}
    typedef struct packed {
        logic [5:0] in;
        logic [5:0] out;
    } vec_t;
    vec_t tbl[$];

    // Reference model: mode 0 fetching, 1 waiting, 2 waiting on a killed refill, 3 halted
    int  m_mode = 0, n_mode;
    int  m_wait = 0, n_wait;
    bit  m_err = 0, n_err;
    longint m_mc = 0, n_mc, m_sc = 0, n_sc;
    localparam longint CMAX = (64'd1 << CNT_W) - 1;

    task automatic add(input logic [5:0] i, input logic [5:0] o);
        vec_t v;
        v.in  = i;
        v.out = o;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [5:0] i);
        {rst_n, ifc.hit_fetch, ifc.refill_done, ifc.branch_taken, ifc.load_use, ifc.halt} = i;
    endtask

    function automatic logic [5:0] observe();
        return {ifc.pc_we, ifc.pc_sel, ifc.ifid_we, ifc.ifid_flush, ifc.refill_req, ifc.timeout_err};
    endfunction

    task automatic model_eval(input logic [5:0] i, output logic [5:0] e);
        logic rn, hit, rd, bt, lu, hl;
        logic we, sel, iwe, fl, rr, te, te_now, entered, waiting;
        {rn, hit, rd, bt, lu, hl} = i;
        {we, sel, iwe, fl, rr} = 5'b0;
        entered = 1'b0;
        n_mode  = m_mode;
        waiting = (m_mode == 1) || (m_mode == 2);
        if (m_mode == 0) begin
            if (bt) begin
                we = 1; sel = 1; fl = 1;
            end else if (hl) begin
                n_mode = 3;
            end else if (!hit) begin
                rr = 1; fl = !lu; entered = 1; n_mode = 1;
            end else if (!lu) begin
                we = 1; iwe = 1;
            end
        end else if (m_mode == 1) begin
            rr = 1; fl = !lu;
            if (bt) begin
                we = 1; sel = 1; fl = 1;
                n_mode = rd ? 0 : 2;
            end else if (rd) begin
                n_mode = 0;
            end
        end else if (m_mode == 2) begin
            rr = 1; fl = 1;
            if (bt) begin
                we = 1; sel = 1;
            end
            if (rd) n_mode = 0;
        end
        te_now = waiting && (m_wait + 1 >= TO) && !rd;
        n_err  = m_err || te_now;
        te     = n_err && (m_mode != 3);
        n_wait = entered ? 0 : (waiting ? m_wait + 1 : m_wait);
        n_mc   = (entered && m_mc < CMAX) ? m_mc + 1 : m_mc;
        n_sc   = (m_mode != 3 && !we && m_sc < CMAX) ? m_sc + 1 : m_sc;
        e = {we, sel, iwe, fl, rr, te};
        if (!rn) begin
            e = 6'b0;
            n_mode = 0; n_wait = 0; n_err = 0; n_mc = 0; n_sc = 0;
        end
    endtask

    task automatic model_commit();
        m_mode = n_mode; m_wait = n_wait; m_err = n_err; m_mc = n_mc; m_sc = n_sc;
    endtask

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    task automatic check_perf(input string name);
`ifdef IF_ID_CTRL_PERF_EN
        longint emc, esc;
        emc = rst_n ? m_mc : 0;
        esc = rst_n ? m_sc : 0;
        total++;
        if (ifc.miss_cnt !== CNT_W'(emc) || ifc.stall_cnt !== CNT_W'(esc)) begin
            bad++;
            $display("FAIL %s perf: got miss=%0d stall=%0d want miss=%0d stall=%0d",
                     name, ifc.miss_cnt, ifc.stall_cnt, emc, esc);
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    initial begin
        logic [5:0] e;
        logic [5:0] r;
        drive(6'b010000);

        add(6'b010000, 6'b000000);
        for (int k = 0; k < 5; k++) add(6'b110000, 6'b101000);
        add(6'b100000, 6'b000110);
        add(6'b100000, 6'b000110);
        add(6'b100000, 6'b000110);
        add(6'b101000, 6'b000110);
        add(6'b110000, 6'b101000);
        add(6'b100000, 6'b000110);
        add(6'b100100, 6'b110110);
        add(6'b100000, 6'b000110);
        add(6'b101000, 6'b000110);
        add(6'b110000, 6'b101000);
        add(6'b100010, 6'b000010);
        add(6'b100010, 6'b000010);
        add(6'b101000, 6'b000110);
        add(6'b110010, 6'b000000);
        add(6'b100110, 6'b110100);
        add(6'b100000, 6'b000110);
        add(6'b100000, 6'b000110);
        add(6'b100000, 6'b000110);
        add(6'b100000, 6'b000110);
        add(6'b100000, 6'b000111);
        add(6'b100000, 6'b000111);
        add(6'b101000, 6'b000111);
        add(6'b110000, 6'b101001);
        add(6'b010000, 6'b000000);
        add(6'b110000, 6'b101000);
        add(6'b110001, 6'b000000);
        add(6'b101111, 6'b000000);
        add(6'b110000, 6'b000000);
        add(6'b010000, 6'b000000);
        add(6'b110000, 6'b101000);
        add(6'b100000, 6'b000110);
        add(6'b101100, 6'b110110);
        add(6'b110000, 6'b101000);
        add(6'b100000, 6'b000110);
        add(6'b100001, 6'b000110);
        add(6'b101001, 6'b000110);
        add(6'b110000, 6'b101000);
        add(6'b110101, 6'b110100);
        add(6'b110000, 6'b101000);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].in);
            #2;
            model_eval(tbl[i].in, e);
            check($sformatf("vec%0d", i), observe(), tbl[i].out);
            check_perf($sformatf("vec%0d", i));
            @(posedge clk);
            #1;
            model_commit();
        end

        for (int c = 0; c < 3000; c++) begin
            r[5] = ($urandom_range(0, 39) != 0);
            r[4] = ($urandom_range(0, 3) != 0);
            r[3] = ($urandom_range(0, 4) == 0);
            r[2] = ($urandom_range(0, 9) == 0);
            r[1] = ($urandom_range(0, 6) == 0);
            r[0] = ($urandom_range(0, 49) == 0);
            drive(r);
            #2;
            model_eval(r, e);
            check($sformatf("rnd%0d", c), observe(), e);
            check_perf($sformatf("rnd%0d", c));
            @(posedge clk);
            #1;
            model_commit();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_id_ctrl.md
# if_id_ctrl

Pipeline-sequencing controller for the IF/ID pipeline register and the PC of the 16-bit RISC core. Each cycle it decides whether the IF/ID register captures, holds, or is loaded with a bubble, and whether the PC advances or loads a branch target. Inputs are the instruction-cache hit flag (`hit_fetch`), the refill handshake, the EX-stage branch redirect, the ID-stage load-use hazard and halt decode. The block sits between the fetch unit, the instruction cache and the IF/ID register.

## Interface
Parameters:
- MISS_TIMEOUT, 64: cycles spent waiting for a refill before `timeout_err` is set; range 2..65535.
- CNT_W, 16: width of the performance counters.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- hit_fetch  in  1  icache hit for the current PC.
- refill_done  in  1  single-cycle pulse; the icache line refill is complete.
- branch_taken  in  1  single-cycle pulse from EX; the PC must load the branch target.
- load_use  in  1  level from ID; the instruction in ID must be held.
- halt  in  1  level from ID; a halt instruction is decoded.
- pc_we  out  1  PC write enable.
- pc_sel  out  1  PC source: 1 = branch target, 0 = PC+1.
- ifid_we  out  1  IF/ID captures the fetched instruction.
- ifid_flush  out  1  IF/ID captures a NOP with `hit_fetch_out` = 0. This has priority over `ifid_we`.
- refill_req  out  1  level request to the icache; held until `refill_done`.
- timeout_err  out  1  sticky flag; cleared only by reset.
- miss_cnt, stall_cnt  out  CNT_W each  exist only with `IF_ID_CTRL_PERF_EN`.

## Operation
States: RUN, MISS, MISS_KILL, HALT.

All outputs are combinational from the current state and inputs. Every output is 0 while `rst_n` = 0. Reset values: state = RUN, timer = 0, `timeout_err` = 0, counters = 0.

Input priority in RUN is branch_taken > halt > load_use > miss.

RUN:
- `branch_taken`: pc_we = 1, pc_sel = 1, ifid_flush = 1. Stay in RUN.
- `halt`: all enables 0. Go to HALT.
- `load_use`: pc_we = 0, ifid_we = 0 (hold). If `hit_fetch` = 0 in the same cycle, also assert refill_req and go to MISS, with ifid_flush = 0.
- `hit_fetch` = 0: pc_we = 0, ifid_flush = 1, refill_req = 1. Go to MISS and clear the timer.
- Otherwise: pc_we = 1, pc_sel = 0, ifid_we = 1.

MISS:
- refill_req = 1, pc_we = 0, ifid_we = 0, ifid_flush = !load_use.
- `refill_done`: go to RUN; the same PC is refetched next cycle.
- `branch_taken` without `refill_done`: pc_we = 1, pc_sel = 1, ifid_flush = 1. Go to MISS_KILL.
- `branch_taken` together with `refill_done`: load the target and go to RUN.

MISS_KILL:
- The refill in flight is for a discarded address. The icache latches its refill address itself when `refill_req` rises.
- refill_req = 1, ifid_flush = 1, pc_we = 0.
- Each further `branch_taken` reloads the PC (pc_we = 1, pc_sel = 1) and stays in MISS_KILL.
- `refill_done`: go to RUN.
- `halt` and `load_use` are ignored here.

HALT:
- All outputs are 0. The block leaves HALT only through reset.
- `halt` is ignored in MISS and MISS_KILL; ID holds a bubble in those states.

Timer:
- Counts every cycle spent in MISS or MISS_KILL and saturates.
- When it reaches MISS_TIMEOUT without `refill_done`, `timeout_err` is set. The block keeps waiting.

## Timing
- A hit fetch has zero stall cycles: the controller does not stall fetch while `hit_fetch` = 1 and there is no hazard.
- Miss penalty = 1 bubble cycle (the RUN→MISS cycle) + N wait cycles until `refill_done` + 1 refetch cycle.
- Branch redirect costs exactly 1 flushed slot, in the same cycle as `branch_taken`.
- `refill_req` rises combinationally in the cycle the miss is detected and falls in the cycle after `refill_done`.
- Reset mid-miss: the next edge returns the state to RUN with `refill_req` = 0. The icache must drop an outstanding refill on reset.

## Configuration
- Macro `IF_ID_CTRL_PERF_EN` defined:
  - `miss_cnt` increments on every RUN→MISS transition.
  - `stall_cnt` increments on every cycle with pc_we = 0 outside HALT.
  - Both counters saturate at all-ones.
- Macro undefined: both ports and all counter logic are absent.

## Structure
- Package `if_id_ctrl_pkg` holds:
  - the state enum (RUN = 0, MISS = 1, MISS_KILL = 2, HALT = 3);
  - NOP encoding 16'h0000 (also used by the IF/ID flush path);
  - the MISS_TIMEOUT default.
- One sub-module, `miss_timer`: a saturating counter with clear, enable and a `timeout` output.

## Test plan
- Reset then `hit_fetch` = 1 for 5 cycles → pc_we = ifid_we = 1 every cycle, no flush.
- `hit_fetch` = 0 in RUN, `refill_done` after 3 cycles → one flush cycle, then refill_req high for 4 cycles, then state RUN; `miss_cnt` = 1 with the macro.
- `branch_taken` in MISS, `refill_done` 2 cycles later → pc_we = pc_sel = 1 once, ifid_flush held through MISS_KILL, then RUN.
- `load_use` = 1 and `hit_fetch` = 0 together → ifid_we = 0 and ifid_flush = 0 while `load_use` = 1; refill_req = 1.
- MISS_TIMEOUT = 4 and no `refill_done` for 6 cycles → `timeout_err` = 1 from the 4th wait cycle; it stays set after `refill_done` until `rst_n` = 0.
- `halt` = 1 in RUN → all outputs 0 indefinitely; `rst_n` low for one edge → RUN.
